// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, frame defaults and baud constants
// used by BaudSync, the transmitter and the receiver.
package uart_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    localparam int CLOCK_HZ      = 100_000_000;
    localparam int BAUD_RATE     = 115_200;
    localparam int BAUD_TICK_DIV = CLOCK_HZ / (BAUD_RATE * DEF_OVERSAMPLE);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input, reset to RST_VAL.
// Latency 2 CLOCK cycles; no flow control.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver: start qualify, mid-bit sampling, stop check.
// RXComplete/FRAME_ERR pulse 1 CLOCK after the mid-stop TICK; no backpressure, strobes are fire-and-forget.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int CNT_W      = 4
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 TICK,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 RXComplete,
    output logic                 FRAME_ERR,
    output logic                 BUSY
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_t            state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 rxc_n, ferr_n;
    logic                 rx_s;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .d     (RX),
        .q     (rx_s)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            DATA       <= '0;
            RXComplete <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            DATA       <= data_n;
            RXComplete <= rxc_n;
            FRAME_ERR  <= ferr_n;
        end
    end

    // Strobes default low every cycle so they stay one CLOCK wide even when TICK is sparse.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = DATA;
        rxc_n   = 1'b0;
        ferr_n  = 1'b0;
        if (TICK) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_n = S_START;
                        cnt_n   = '0;
                    end
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        cnt_n   = '0;
                        idx_n   = '0;
                        state_n = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt_n   = '0;
                        shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                        if (idx == LAST_IDX) begin
                            idx_n   = '0;
                            state_n = S_STOP;
                        end else begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt_n = '0;
                        if (rx_s) begin
                            data_n  = shreg;
                            rxc_n   = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: table of framed bytes plus hand-written corner sequences.
module tb_uart_rx_engine;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       TICK  = 1'b1;
    logic       RX    = 1'b1;
    logic [7:0] DATA;
    logic       RXComplete;
    logic       FRAME_ERR;
    logic       BUSY;

    uart_rx_engine #(.DATA_BITS(8), .OVERSAMPLE(16), .CNT_W(4)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .TICK       (TICK),
        .RX         (RX),
        .DATA       (DATA),
        .RXComplete (RXComplete),
        .FRAME_ERR  (FRAME_ERR),
        .BUSY       (BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    int div = 1;
    int tick_cnt = 0;
    always @(negedge CLOCK) begin
        if (tick_cnt >= div - 1) tick_cnt = 0;
        else tick_cnt = tick_cnt + 1;
        TICK = (tick_cnt == 0);
    end

    int         cyc = 0;
    int         rxc_cnt = 0, ferr_cnt = 0, both_cnt = 0, wide_cnt = 0;
    int         last_rxc_cyc = 0, prev_rxc_cyc = 0;
    logic [7:0] last_data = 8'h00, prev_data = 8'h00;
    logic       rxc_d = 1'b0, ferr_d = 1'b0;

    always @(negedge CLOCK) begin
        cyc = cyc + 1;
        if (RXComplete) begin
            rxc_cnt      = rxc_cnt + 1;
            prev_rxc_cyc = last_rxc_cyc;
            last_rxc_cyc = cyc;
            prev_data    = last_data;
            last_data    = DATA;
        end
        if (FRAME_ERR) ferr_cnt = ferr_cnt + 1;
        if (RXComplete && FRAME_ERR) both_cnt = both_cnt + 1;
        if ((RXComplete && rxc_d) || (FRAME_ERR && ferr_d)) wide_cnt = wide_cnt + 1;
        rxc_d  = RXComplete;
        ferr_d = FRAME_ERR;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bitc);
        RX = 1'b0;
        wait_clk(bitc);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            wait_clk(bitc);
        end
        RX = stop;
        wait_clk(bitc);
        RX = 1'b1;
    endtask

    typedef struct {
        int         div;
        logic [7:0] b;
        logic       stop;
        int         exp_rxc;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];
    int   r0, f0;

    initial begin
        vecs[0] = '{1, 8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{1, 8'h3C, 1'b0, 0, 1, 8'hA5};
        vecs[2] = '{1, 8'h81, 1'b1, 1, 0, 8'h81};
        vecs[3] = '{4, 8'h96, 1'b1, 1, 0, 8'h96};
        vecs[4] = '{4, 8'hE7, 1'b0, 0, 1, 8'h96};
        vecs[5] = '{4, 8'h7E, 1'b1, 1, 0, 8'h7E};

        wait_clk(3);
        check("reset_data", 32'(DATA), 32'h00);
        check("reset_rxc", 32'(RXComplete), 32'h0);
        check("reset_ferr", 32'(FRAME_ERR), 32'h0);
        check("reset_busy", 32'(BUSY), 32'h0);
        RESET = 1'b0;
        wait_clk(4);
        check("idle_busy", 32'(BUSY), 32'h0);

        for (int i = 0; i < 6; i++) begin
            div = vecs[i].div;
            wait_clk(8);
            r0 = rxc_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].b, vecs[i].stop, 16 * div);
            wait_clk(32 * div);
            check($sformatf("vec%0d_rxc", i), 32'(rxc_cnt - r0), 32'(vecs[i].exp_rxc));
            check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_data", i), 32'(DATA), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_busy", i), 32'(BUSY), 32'h0);
        end

        // Start glitch shorter than half a bit
        div = 1;
        wait_clk(8);
        r0 = rxc_cnt;
        f0 = ferr_cnt;
        RX = 1'b0;
        wait_clk(4);
        RX = 1'b1;
        wait_clk(2);
        check("glitch_busy_hi", 32'(BUSY), 32'h1);
        wait_clk(8);
        check("glitch_busy_lo", 32'(BUSY), 32'h0);
        check("glitch_rxc", 32'(rxc_cnt - r0), 32'h0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'h0);
        check("glitch_data", 32'(DATA), 32'h7E);

        // Back-to-back frames, no idle gap
        wait_clk(16);
        r0 = rxc_cnt;
        send_frame(8'h00, 1'b1, 16);
        send_frame(8'hFF, 1'b1, 16);
        wait_clk(32);
        check("b2b_rxc", 32'(rxc_cnt - r0), 32'h2);
        check("b2b_spacing", 32'(last_rxc_cyc - prev_rxc_cyc), 32'd160);
        check("b2b_first", 32'(prev_data), 32'h00);
        check("b2b_second", 32'(last_data), 32'hFF);
        check("b2b_data", 32'(DATA), 32'hFF);

        // Break: line held low well past a frame
        r0 = rxc_cnt;
        f0 = ferr_cnt;
        RX = 1'b0;
        wait_clk(200);
        check("break_busy", 32'(BUSY), 32'h1);
        check("break_ferr", 32'(ferr_cnt - f0), 32'h1);
        RX = 1'b1;
        wait_clk(32);
        check("break_release_busy", 32'(BUSY), 32'h0);
        check("break_rxc", 32'(rxc_cnt - r0), 32'h0);
        check("break_data", 32'(DATA), 32'hFF);
        send_frame(8'h5A, 1'b1, 16);
        wait_clk(32);
        check("after_break_data", 32'(DATA), 32'h5A);

        // Reset after three data bits of 0xC3
        r0 = rxc_cnt;
        f0 = ferr_cnt;
        RX = 1'b0; wait_clk(16);
        RX = 1'b1; wait_clk(16);
        RX = 1'b1; wait_clk(16);
        RX = 1'b0; wait_clk(16);
        RESET = 1'b1;
        #1;
        check("midrst_data", 32'(DATA), 32'h00);
        check("midrst_busy", 32'(BUSY), 32'h0);
        RX = 1'b1;
        wait_clk(2);
        RESET = 1'b0;
        wait_clk(32);
        check("midrst_no_strobe", 32'(rxc_cnt - r0 + ferr_cnt - f0), 32'h0);
        r0 = rxc_cnt;
        send_frame(8'h7E, 1'b1, 16);
        wait_clk(32);
        check("midrst_rxc", 32'(rxc_cnt - r0), 32'h1);
        check("midrst_data_after", 32'(DATA), 32'h7E);

        check("strobe_overlap", 32'(both_cnt), 32'h0);
        check("strobe_width", 32'(wide_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
